iccm_loader: RTL
================

# iccm_loader

Boot-time program loader for the instruction memory's ICCM controller port. It assembles a byte stream from the UART receiver into 32-bit words and writes them to consecutive ICCM word addresses. It holds the core's program reset low while loading and releases it when an end-of-program word arrives or the memory is full. Its outputs connect directly to the instruction memory's `iccm_ctrl_addr`, `iccm_ctrl_wdata`, `iccm_ctrl_we` and `prog_rst_ni` inputs.

## Interface
Parameters:
- `AW`, 12: word-address width; capacity is 2^AW words.
- `END_WORD`, 32'h0000_0FFF: end-of-program marker word; never written to memory.

Ports:
- `clk_i`  in  1  clock; one clock domain.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `rx_byte_i`  in  8  received byte; valid only while `rx_valid_i`=1.
- `rx_valid_i`  in  1  one-cycle strobe, one byte per strobe; may be high on consecutive cycles.
- `addr_o`  out  AW  ICCM word address of the current write.
- `wdata_o`  out  32  ICCM write data.
- `we_o`  out  1  one-cycle write strobe.
- `prog_rst_no`  out  1  0 = core held in reset / ICCM owned by loader; 1 = released.
- `done_o`  out  1  load finished; sticky until `rst_ni`.

## Operation
- Reset values: `addr_o`=0, `wdata_o`=0, `we_o`=0, `prog_rst_no`=0, `done_o`=0, byte count=0, write pointer=0, state LOAD.
- Byte assembly is little-endian:
  - first byte of a word → bits [7:0], then [15:8], [23:16], [31:24];
  - a 2-bit byte counter tracks position in the word;
  - the assembly register is separate from `wdata_o`.
- State LOAD:
  - each strobe stores the byte and increments the counter;
  - on the 4th strobe, the completed word W is compared with `END_WORD`, and the counter wraps to 0 in the same cycle.
- W == `END_WORD`:
  - go to DONE;
  - no `we_o` pulse;
  - the write pointer is unchanged.
- W != `END_WORD`:
  - register `wdata_o`=W and `addr_o`=pointer;
  - pulse `we_o`;
  - increment the pointer.
  - If the pointer was 2^AW−1, go to DONE instead of staying in LOAD (memory full). No wrap to 0.
- State DONE:
  - `prog_rst_no`=1 and `done_o`=1;
  - all `rx_valid_i` strobes ignored;
  - `we_o` stays 0;
  - `addr_o`/`wdata_o` hold their last values;
  - exit only via `rst_ni`.
- Partial words (1–3 bytes) are held indefinitely; there is no timeout.
- Reset mid-word or mid-write discards partial bytes and the pointer. Reload restarts at address 0.

## Timing
- 4th byte strobe in cycle N:
  - `we_o`=1 in N+1 only;
  - `addr_o`/`wdata_o` are valid in N+1 and held until the next write;
  - `addr_o` presents the pre-increment address during the pulse.
- Back-to-back bytes:
  - a strobe in cycle N+1 is accepted as byte 0 of the next word, concurrently with the `we_o` pulse;
  - sustained rate is one byte per cycle, one write per 4 cycles, with no stalls.
- End marker completed in cycle N: `prog_rst_no` and `done_o` rise in N+1.
- Last-address write completed in cycle N: `we_o`=1 in N+1; `prog_rst_no`/`done_o` rise in N+1, the same cycle as the final write pulse.
- All outputs are registered. `rst_ni` assertion forces reset values immediately, without waiting for a clock edge.

## Test plan
- Reset check: assert `rst_ni`=0 mid-cycle.
  - Outputs go to 0 immediately: `prog_rst_no`=0, `we_o`=0, `addr_o`=0.
- Single word: bytes 0x13,0x05,0x00,0x00 with gaps between them.
  - Exactly one `we_o` pulse, one cycle after the last byte, with `addr_o`=0 and `wdata_o`=0x0000_0513.
- Streaming: 12 bytes on consecutive cycles, then 0xFF,0x0F,0x00,0x00.
  - Three pulses, at addr 0,1,2, 4 cycles apart, with correct words.
  - No 4th pulse.
  - `prog_rst_no`=1 and `done_o`=1 one cycle after the final 0x00.
  - Further bytes produce no `we_o`.
- Reset mid-word: 2 bytes sent, `rst_ni` pulsed, then 0xAA,0xBB,0xCC,0xDD.
  - Write with addr 0, wdata 0xDDCC_BBAA.
- Capacity, with AW=3: send 8 non-marker words.
  - Pulses at addr 0..7.
  - `done_o` rises together with the addr-7 pulse.
  - A 9th word produces no write, and `addr_o` stays 7.
- Marker as the first word: FF,0F,00,00 straight after reset.
  - Zero writes; `prog_rst_no`=1 one cycle after the last byte.

Source files
------------

// File: rtl/iccm_loader.sv
// Boot loader that turns a UART byte stream into 32-bit ICCM writes.
// Holds the core's program reset low until an end marker arrives or the memory is full.
module iccm_loader #(
    parameter int unsigned AW       = 12,
    parameter logic [31:0] END_WORD = 32'h0000_0FFF
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [7:0]    rx_byte_i,
    input  logic          rx_valid_i,
    output logic [AW-1:0] addr_o,
    output logic [31:0]   wdata_o,
    output logic          we_o,
    output logic          prog_rst_no,
    output logic          done_o
);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_DONE = 1'b1
    } state_e;

    localparam logic [AW-1:0] PTR_MAX = '1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [23:0]   asm_q, asm_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [31:0]   word;

    // The fourth byte completes the word directly from the input, so no extra cycle is spent.
    assign word = {rx_byte_i, asm_q};

    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;

        if (state_q == S_LOAD && rx_valid_i) begin
            cnt_d = cnt_q + 2'd1;
            case (cnt_q)
                2'd0: asm_d[7:0]   = rx_byte_i;
                2'd1: asm_d[15:8]  = rx_byte_i;
                2'd2: asm_d[23:16] = rx_byte_i;
                default: begin
                    if (word == END_WORD) begin
                        state_d = S_DONE;
                    end else begin
                        wdata_d = word;
                        addr_d  = ptr_q;
                        we_d    = 1'b1;
                        // A full memory ends the load; the pointer never wraps back to 0.
                        if (ptr_q == PTR_MAX) begin
                            state_d = S_DONE;
                        end else begin
                            ptr_d = ptr_q + PTR_ONE;
                        end
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_LOAD;
            cnt_q   <= 2'd0;
            asm_q   <= 24'd0;
            ptr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
    assign we_o        = we_q;
    assign prog_rst_no = (state_q == S_DONE);
    assign done_o      = (state_q == S_DONE);

endmodule
